pattern_detect_reg: RTL and testbench

Output register stage for the DSP slice pattern detector. Captures the accumulator result P and the raw combinational PATTERN_DETECT / PATTERNB_DETECT flags computed on that result. From the registered flags it derives past flags, OVERFLOW / UNDERFLOW and a match counter. It also drives the auto-reset of the P register, closing the loop from the detector back into the accumulator.

---
 rtl/dsp_slice_pkg.sv | 36 +++
 rtl/pattern_detect_reg_if.sv | 33 +++
 rtl/pattern_detect_reg.sv | 81 ++++++++
 tb/tb_pattern_detect_reg.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_slice_pkg.sv
// Shared DSP slice constants and payload types.
package dsp_slice_pkg;

    localparam int unsigned P_W = 48;

    // Auto-reset modes for the pattern detector output stage
    localparam int unsigned AR_NO_RESET        = 0;
    localparam int unsigned AR_RESET_MATCH     = 1;
    localparam int unsigned AR_RESET_NOT_MATCH = 2;

    // Auto-reset priority relative to CEP
    localparam int unsigned AR_PRI_RESET = 0;
    localparam int unsigned AR_PRI_CEP   = 1;

    // Result word captured together with its detector flags
    typedef struct packed {
        logic [P_W-1:0] p;
        logic           pd;
        logic           pbd;
    } pd_capture_t;

    // Raw auto-reset request from the registered flags
    function automatic logic autoreset_req(input int unsigned mode,
                                           input logic pd_q,
                                           input logic pd_past_q);
        logic req;
        req = 1'b0;
        if (mode == AR_RESET_MATCH) begin
            req = pd_q;
        end else if (mode == AR_RESET_NOT_MATCH) begin
            req = pd_past_q & ~pd_q;
        end
        return req;
    endfunction

endpackage

// File: rtl/pattern_detect_reg_if.sv
// Bus between the accumulator/detector side and the detector output register.
interface pattern_detect_reg_if
    import dsp_slice_pkg::*;
#(
    parameter int unsigned CNT_W = 8
);
    logic             CEP;
    logic [P_W-1:0]   P_IN;
    logic             PD_IN;
    logic             PBD_IN;
    logic             CNT_CLR;
    logic [P_W-1:0]   P;
    logic             PATTERN_DETECT;
    logic             PATTERNB_DETECT;
    logic             PATTERN_DETECT_PAST;
    logic             PATTERNB_DETECT_PAST;
    logic             OVERFLOW;
    logic             UNDERFLOW;
    logic [CNT_W-1:0] MATCH_CNT;

    modport master (
        output CEP, P_IN, PD_IN, PBD_IN, CNT_CLR,
        input  P, PATTERN_DETECT, PATTERNB_DETECT, PATTERN_DETECT_PAST,
               PATTERNB_DETECT_PAST, OVERFLOW, UNDERFLOW, MATCH_CNT
    );

    modport slave (
        input  CEP, P_IN, PD_IN, PBD_IN, CNT_CLR,
        output P, PATTERN_DETECT, PATTERNB_DETECT, PATTERN_DETECT_PAST,
               PATTERNB_DETECT_PAST, OVERFLOW, UNDERFLOW, MATCH_CNT
    );

endinterface

// File: rtl/pattern_detect_reg.sv
// Pattern detector output register: captures P and flags, derives past flags,
// overflow/underflow, a saturating match counter and the P auto-reset.
module pattern_detect_reg
    import dsp_slice_pkg::*;
#(
    parameter int unsigned AUTORESET_PATDET   = AR_NO_RESET,
    parameter int unsigned AUTORESET_PRIORITY = AR_PRI_RESET,
    parameter int unsigned CNT_W              = 8
) (
    input logic                CLK,
    input logic                RSTP,
    pattern_detect_reg_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pd_capture_t      cap_q;
    logic             pd_past_q;
    logic             pbd_past_q;
    logic [CNT_W-1:0] cnt_q;

    logic             ar_c;
    logic             ar_en_c;
    logic             cnt_inc_c;

    // Auto-reset request, gated by CEP when the priority mode asks for it
    always_comb begin
        ar_c      = 1'b0;
        ar_en_c   = 1'b0;
        cnt_inc_c = 1'b0;
        ar_c      = autoreset_req(AUTORESET_PATDET, cap_q.pd, pd_past_q);
        if (AUTORESET_PRIORITY == AR_PRI_CEP) begin
            ar_en_c = ar_c & bus.CEP;
        end else begin
            ar_en_c = ar_c;
        end
        cnt_inc_c = ~ar_en_c & bus.CEP & bus.PD_IN & (cnt_q != CNT_MAX);
    end

    // Result/flag capture with auto-reset taking priority over CEP
    always_ff @(posedge CLK) begin
        if (RSTP) begin
            cap_q      <= '0;
            pd_past_q  <= 1'b0;
            pbd_past_q <= 1'b0;
        end else if (ar_en_c) begin
            cap_q      <= '0;
            pd_past_q  <= cap_q.pd;
            pbd_past_q <= cap_q.pbd;
        end else if (bus.CEP) begin
            cap_q.p    <= bus.P_IN;
            cap_q.pd   <= bus.PD_IN;
            cap_q.pbd  <= bus.PBD_IN;
            pd_past_q  <= cap_q.pd;
            pbd_past_q <= cap_q.pbd;
        end
    end

    // Saturating count of captured matches; clear wins over increment
    always_ff @(posedge CLK) begin
        if (RSTP) begin
            cnt_q <= '0;
        end else if (bus.CNT_CLR) begin
            cnt_q <= '0;
        end else if (cnt_inc_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.P                    = cap_q.p;
    assign bus.PATTERN_DETECT       = cap_q.pd;
    assign bus.PATTERNB_DETECT      = cap_q.pbd;
    assign bus.PATTERN_DETECT_PAST  = pd_past_q;
    assign bus.PATTERNB_DETECT_PAST = pbd_past_q;
    assign bus.MATCH_CNT            = cnt_q;

    // A previous match that has now fallen to neither pattern nor complement
    assign bus.OVERFLOW  = pd_past_q  & ~cap_q.pd & ~cap_q.pbd;
    assign bus.UNDERFLOW = pbd_past_q & ~cap_q.pd & ~cap_q.pbd;

endmodule

// File: tb/tb_pattern_detect_reg.sv
// Scoreboard bench for pattern_detect_reg across several auto-reset configs.
module tb_pattern_detect_reg;

    localparam int unsigned NDUT = 5;

    typedef struct {
        logic [47:0] p;
        logic        pd;
        logic        pbd;
        logic        pdp;
        logic        pbdp;
        logic        ovf;
        logic        unf;
        int unsigned cnt;
    } exp_t;

    // DUT configs: 0 no-reset, 1 match/reset-pri, 2 match/cep-pri,
    // 3 not-match/reset-pri, 4 no-reset with a 2-bit counter
    function automatic int unsigned f_mode(input int i);
        case (i)
            1, 2:    return 1;
            3:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned f_pri(input int i);
        return (i == 2) ? 1 : 0;
    endfunction

    function automatic int unsigned f_cw(input int i);
        return (i == 4) ? 2 : 8;
    endfunction

    logic        clk;
    logic        rstp;
    logic        cep;
    logic [47:0] p_in;
    logic        pd_in;
    logic        pbd_in;
    logic        cnt_clr;

    logic [47:0] o_p    [NDUT];
    logic        o_pd   [NDUT];
    logic        o_pbd  [NDUT];
    logic        o_pdp  [NDUT];
    logic        o_pbdp [NDUT];
    logic        o_ovf  [NDUT];
    logic        o_unf  [NDUT];
    logic [31:0] o_cnt  [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned CW = f_cw(g);
        pattern_detect_reg_if #(.CNT_W(CW)) u_if ();
        assign u_if.CEP     = cep;
        assign u_if.P_IN    = p_in;
        assign u_if.PD_IN   = pd_in;
        assign u_if.PBD_IN  = pbd_in;
        assign u_if.CNT_CLR = cnt_clr;
        pattern_detect_reg #(
            .AUTORESET_PATDET   (f_mode(g)),
            .AUTORESET_PRIORITY (f_pri(g)),
            .CNT_W              (CW)
        ) u_dut (
            .CLK  (clk),
            .RSTP (rstp),
            .bus  (u_if)
        );
        assign o_p[g]    = u_if.P;
        assign o_pd[g]   = u_if.PATTERN_DETECT;
        assign o_pbd[g]  = u_if.PATTERNB_DETECT;
        assign o_pdp[g]  = u_if.PATTERN_DETECT_PAST;
        assign o_pbdp[g] = u_if.PATTERNB_DETECT_PAST;
        assign o_ovf[g]  = u_if.OVERFLOW;
        assign o_unf[g]  = u_if.UNDERFLOW;
        assign o_cnt[g]  = 32'(u_if.MATCH_CNT);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb[$];

    // Reference state per DUT
    logic [47:0] m_p    [NDUT];
    logic        m_pd   [NDUT];
    logic        m_pbd  [NDUT];
    logic        m_pdp  [NDUT];
    logic        m_pbdp [NDUT];
    int unsigned m_cnt  [NDUT];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int i);
        logic ar;
        logic are;
        int unsigned cmax;
        cmax = (1 << f_cw(i)) - 1;
        case (f_mode(i))
            1:       ar = m_pd[i];
            2:       ar = m_pdp[i] & ~m_pd[i];
            default: ar = 1'b0;
        endcase
        are = (f_pri(i) == 1) ? (ar & cep) : ar;
        if (rstp) begin
            m_p[i] = '0; m_pd[i] = 0; m_pbd[i] = 0;
            m_pdp[i] = 0; m_pbdp[i] = 0; m_cnt[i] = 0;
        end else begin
            if (cnt_clr) m_cnt[i] = 0;
            else if (!are && cep && pd_in && m_cnt[i] < cmax) m_cnt[i] = m_cnt[i] + 1;
            if (are) begin
                m_pdp[i] = m_pd[i]; m_pbdp[i] = m_pbd[i];
                m_p[i] = '0; m_pd[i] = 0; m_pbd[i] = 0;
            end else if (cep) begin
                m_pdp[i] = m_pd[i]; m_pbdp[i] = m_pbd[i];
                m_p[i] = p_in; m_pd[i] = pd_in; m_pbd[i] = pbd_in;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic c, input logic [47:0] pv,
                         input logic d, input logic b, input logic cl);
        exp_t e;
        @(negedge clk);
        rstp = r; cep = c; p_in = pv; pd_in = d; pbd_in = b; cnt_clr = cl;
        for (int i = 0; i < NDUT; i++) begin
            model_step(i);
            e.p = m_p[i]; e.pd = m_pd[i]; e.pbd = m_pbd[i];
            e.pdp = m_pdp[i]; e.pbdp = m_pbdp[i]; e.cnt = m_cnt[i];
            e.ovf = m_pdp[i] & ~m_pd[i] & ~m_pbd[i];
            e.unf = m_pbdp[i] & ~m_pd[i] & ~m_pbd[i];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            if (sb.size() == 0) begin
                check($sformatf("sb_empty%0d", i), 64'(sb.size()), 64'(1));
            end else begin
                e = sb.pop_front();
                check($sformatf("p%0d", i),    64'(o_p[i]),    64'(e.p));
                check($sformatf("pd%0d", i),   64'(o_pd[i]),   64'(e.pd));
                check($sformatf("pbd%0d", i),  64'(o_pbd[i]),  64'(e.pbd));
                check($sformatf("pdp%0d", i),  64'(o_pdp[i]),  64'(e.pdp));
                check($sformatf("pbdp%0d", i), 64'(o_pbdp[i]), 64'(e.pbdp));
                check($sformatf("ovf%0d", i),  64'(o_ovf[i]),  64'(e.ovf));
                check($sformatf("unf%0d", i),  64'(o_unf[i]),  64'(e.unf));
                check($sformatf("cnt%0d", i),  64'(o_cnt[i]),  64'(e.cnt));
            end
        end
    endtask

    initial begin
        rstp = 1'b0; cep = 1'b0; p_in = '0; pd_in = 1'b0; pbd_in = 1'b0; cnt_clr = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            m_p[i] = '0; m_pd[i] = 0; m_pbd[i] = 0; m_pdp[i] = 0; m_pbdp[i] = 0; m_cnt[i] = 0;
        end

        // Reset with live inputs
        cycle(1, 1, 48'd5, 1, 0, 0);
        check("rst_p", 64'(o_p[0]), 64'd0);
        check("rst_pd", 64'(o_pd[0]), 64'd0);
        check("rst_cnt", 64'(o_cnt[0]), 64'd0);

        // Capture and count
        cycle(0, 1, 48'd2, 1, 0, 0);
        check("cap_p", 64'(o_p[0]), 64'd2);
        cycle(0, 1, 48'd2, 1, 0, 0);
        cycle(0, 1, 48'd2, 1, 0, 0);
        check("cap_pdp", 64'(o_pdp[0]), 64'd1);
        cycle(0, 1, 48'd2, 0, 0, 0);
        check("cap_cnt", 64'(o_cnt[0]), 64'd3);
        cycle(0, 1, 48'd2, 0, 0, 0);

        // Overflow then underflow, one cycle each
        cycle(0, 1, 48'd3, 1, 0, 0);
        cycle(0, 1, 48'd3, 0, 0, 0);
        check("ovf_hi", 64'(o_ovf[0]), 64'd1);
        cycle(0, 1, 48'd3, 0, 0, 0);
        check("ovf_lo", 64'(o_ovf[0]), 64'd0);
        cycle(0, 1, 48'd4, 0, 1, 0);
        cycle(0, 1, 48'd4, 0, 0, 0);
        check("unf_hi", 64'(o_unf[0]), 64'd1);
        cycle(0, 1, 48'd4, 0, 0, 0);
        check("unf_lo", 64'(o_unf[0]), 64'd0);

        // Mode 1 with both priorities
        cycle(1, 0, 48'd0, 0, 0, 0);
        cycle(0, 1, 48'd2, 1, 0, 0);
        cycle(0, 0, 48'd2, 0, 0, 0);
        check("m1r_p", 64'(o_p[1]), 64'd0);
        check("m1r_pd", 64'(o_pd[1]), 64'd0);
        check("m1c_p", 64'(o_p[2]), 64'd2);
        cycle(0, 0, 48'd2, 0, 0, 0);
        check("m1c_hold", 64'(o_p[2]), 64'd2);
        cycle(0, 1, 48'd3, 0, 0, 0);
        check("m1c_clr", 64'(o_p[2]), 64'd0);

        // Mode 2: match, then non-match, then auto-reset
        cycle(1, 0, 48'd0, 0, 0, 0);
        cycle(0, 1, 48'd1, 1, 0, 0);
        cycle(0, 1, 48'd7, 0, 0, 0);
        check("m2_p7", 64'(o_p[3]), 64'd7);
        cycle(0, 1, 48'd9, 0, 0, 0);
        check("m2_clr", 64'(o_p[3]), 64'd0);

        // Counter saturation and clear-beats-increment
        cycle(1, 0, 48'd0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cycle(0, 1, 48'd4, 1, 0, 0);
        check("sat_cnt2", 64'(o_cnt[4]), 64'd3);
        check("sat_cnt8", 64'(o_cnt[0]), 64'd5);
        cycle(0, 1, 48'd4, 1, 0, 1);
        check("clr_cnt", 64'(o_cnt[0]), 64'd0);

        // Both detector flags together
        cycle(0, 1, 48'd6, 1, 1, 0);
        check("both_ovf", 64'(o_ovf[0]), 64'd0);
        check("both_unf", 64'(o_unf[0]), 64'd0);
        cycle(0, 1, 48'd6, 0, 0, 0);

        // Mid-operation reset overrides CEP and CNT_CLR
        cycle(0, 1, 48'd8, 1, 0, 0);
        cycle(1, 0, 48'd5, 1, 0, 1);
        check("mid_rst_p", 64'(o_p[0]), 64'd0);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            cycle(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0),
                  48'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
